// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Round-robin sharing of one pipelined Wishbone slave among NM
//            masters, with outstanding-ack tracking so acks reach their owner.
// Revision : 1.0
// ============================================================================
module wb_arbiter #(
    parameter int NM     = 2,
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int MAXOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NM-1:0]     m_cyc,
    input  logic [NM-1:0]     m_stb,
    input  logic [NM-1:0]     m_we,
    input  logic [NM*AW-1:0]  m_adr,
    input  logic [NM*DW-1:0]  m_dat_i,
    output logic [DW-1:0]     m_dat_o,
    output logic [NM-1:0]     m_ack,
    output logic [NM-1:0]     m_stall,
    output logic [NM-1:0]     gnt,
    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [AW-1:0]     s_adr,
    output logic [DW-1:0]     s_dat_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack,
    input  logic              s_stall
);

    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = $clog2(MAXOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NM-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   gidx_q, gidx_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            w_accept;
    logic            w_ack_valid;
    logic            w_release;
    logic [GW-1:0]   w_rel_ptr;
    logic [GW:0]     w_idle_pick;
    logic [GW:0]     w_rel_pick;

    // Returns {found, index} of the first requester at or after base, wrapping.
    function automatic logic [GW:0] pick_next(input logic [NM-1:0] req,
                                              input logic [GW-1:0] base);
        logic [GW:0] res;
        int          idx;
        res = '0;
        for (int i = NM - 1; i >= 0; i--) begin
            idx = int'(base) + i;
            if (idx >= NM) begin
                idx = idx - NM;
            end
            if (req[idx]) begin
                res = {1'b1, idx[GW-1:0]};
            end
        end
        return res;
    endfunction

    assign m_dat_o = s_dat_i;
    assign gnt     = gnt_q;

    always_comb begin
        s_cyc   = (state_q != ST_IDLE);
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_o = '0;
        m_stall = '1;
        m_ack   = '0;
        if (state_q == ST_OWNED) begin
            s_stb           = m_stb[gidx_q] & (cnt_q < CNT_MAX);
            s_we            = m_we[gidx_q];
            s_adr           = m_adr[int'(gidx_q)*AW +: AW];
            s_dat_o         = m_dat_i[int'(gidx_q)*DW +: DW];
            m_stall[gidx_q] = s_stall | (cnt_q == CNT_MAX);
            m_ack[gidx_q]   = s_ack & (cnt_q != '0);
        end
    end

    // Acks with nothing outstanding are protocol errors and must not move the count.
    assign w_accept    = s_stb & ~s_stall;
    assign w_ack_valid = s_ack & (cnt_q != '0) & (state_q != ST_IDLE);

    always_comb begin
        cnt_d = cnt_q;
        if (w_accept && !w_ack_valid) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!w_accept && w_ack_valid) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign w_rel_ptr   = (gidx_q == GW'(NM - 1)) ? '0 : gidx_q + 1'b1;
    assign w_idle_pick = pick_next(m_cyc, ptr_q);
    assign w_rel_pick  = pick_next(m_cyc, w_rel_ptr);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        w_release = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_idle_pick[GW]) begin
                    state_d = ST_OWNED;
                    gidx_d  = w_idle_pick[GW-1:0];
                    gnt_d   = '0;
                    gnt_d[w_idle_pick[GW-1:0]] = 1'b1;
                end
            end
            ST_OWNED: begin
                if (!m_cyc[gidx_q]) begin
                    if (cnt_d == '0) begin
                        w_release = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_d == '0) begin
                    w_release = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        // Hand over directly to the next requester so there is no idle bubble.
        if (w_release) begin
            ptr_d = w_rel_ptr;
            gnt_d = '0;
            if (w_rel_pick[GW]) begin
                state_d = ST_OWNED;
                gidx_d  = w_rel_pick[GW-1:0];
                gnt_d[w_rel_pick[GW-1:0]] = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Scoreboard bench for wb_arbiter with two masters and a
//            variable-latency pipelined slave model.
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter;

    localparam int NM     = 2;
    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int MAXOUT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat_i;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack, m_stall, gnt;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack, s_stall;

    always #5 clk = ~clk;

    wb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MAXOUT(MAXOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_cyc   (m_cyc),
        .m_stb   (m_stb),
        .m_we    (m_we),
        .m_adr   (m_adr),
        .m_dat_i (m_dat_i),
        .m_dat_o (m_dat_o),
        .m_ack   (m_ack),
        .m_stall (m_stall),
        .gnt     (gnt),
        .s_cyc   (s_cyc),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_adr   (s_adr),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_ack   (s_ack),
        .s_stall (s_stall)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } op_t;

    typedef struct packed {
        logic [31:0]   due;
        logic [DW-1:0] dat;
    } sp_t;

    op_t          ops   [NM][$];
    logic [DW:0]  exp_q [NM][$];
    sp_t          spq[$];
    logic [NM-1:0] cyc_nx;
    logic [NM-1:0] auto_drop;
    int           ack_cnt [NM];
    int           cyc_n;
    int           lat;
    int           rr_ptr;
    logic         inj_ack;
    logic         saw_full;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] adr);
        return adr ^ 16'h5A5A;
    endfunction

    // One bus cycle: drive at the falling edge, observe just before the rising edge.
    task automatic step();
        logic [DW:0] e;
        op_t         o;
        logic        slave_pop;
        @(negedge clk);
        cyc_n++;
        m_cyc = cyc_nx;
        for (int i = 0; i < NM; i++) begin
            if (m_cyc[i] && ops[i].size() > 0) begin
                m_stb[i]                = 1'b1;
                m_we[i]                 = ops[i][0].we;
                m_adr[i*AW +: AW]       = ops[i][0].adr;
                m_dat_i[i*DW +: DW]     = ops[i][0].dat;
            end else begin
                m_stb[i] = 1'b0;
                m_we[i]  = 1'b0;
            end
        end
        slave_pop = (spq.size() > 0) && (spq[0].due <= 32'(cyc_n));
        s_ack   = slave_pop | inj_ack;
        s_dat_i = slave_pop ? spq[0].dat : '0;
        #4;
        for (int i = 0; i < NM; i++) begin
            if (gnt[i] && m_cyc[i] && exp_q[i].size() == MAXOUT) begin
                saw_full = 1'b1;
                check_eq("stall_at_max", 32'(m_stall[i]), 32'd1);
            end
        end
        for (int i = 0; i < NM; i++) begin
            if (m_ack[i]) begin
                if (exp_q[i].size() == 0) begin
                    check_eq("stray_ack", 32'(i + 1), 32'd0);
                end else begin
                    e = exp_q[i].pop_front();
                    ack_cnt[i]++;
                    if (!e[DW]) check_eq("rd_data", 32'(m_dat_o), 32'(e[DW-1:0]));
                end
            end
        end
        if (slave_pop) void'(spq.pop_front());
        for (int i = 0; i < NM; i++) begin
            if (m_stb[i] && !m_stall[i]) begin
                o = ops[i].pop_front();
                check_eq("s_stb", 32'(s_stb), 32'd1);
                check_eq("s_adr", 32'(s_adr), 32'(o.adr));
                check_eq("s_we", 32'(s_we), 32'(o.we));
                if (o.we) check_eq("s_dat_o", 32'(s_dat_o), 32'(o.dat));
                exp_q[i].push_back({o.we, o.we ? '0 : rd_data(o.adr)});
                check_eq("outstanding_le_max", 32'(exp_q[i].size() <= MAXOUT), 32'd1);
            end
        end
        if (s_stb && !s_stall) spq.push_back({32'(cyc_n + lat), rd_data(s_adr)});
        for (int i = 0; i < NM; i++) begin
            if (auto_drop[i] && m_cyc[i] && ops[i].size() == 0 && exp_q[i].size() == 0)
                cyc_nx[i] = 1'b0;
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < NM; i++) begin
            ops[i].delete();
            exp_q[i].delete();
        end
        spq.delete();
        cyc_nx    = '0;
        auto_drop = '0;
        m_cyc     = '0;
        m_stb     = '0;
        m_we      = '0;
        s_ack     = 1'b0;
        inj_ack   = 1'b0;
        rr_ptr    = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_models();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drop(input int i);
        int k;
        k = 0;
        while (m_cyc[i] && k < 60) begin
            step();
            k++;
        end
        if (m_cyc[i]) check_eq("timeout_drop", 32'(i), 32'hFFFF);
    endtask

    // Each master in mask performs one write; grant order follows round-robin.
    task automatic contend(input logic [1:0] mask, input int tagn);
        int first, second;
        for (int i = 0; i < NM; i++) begin
            if (mask[i]) ops[i].push_back({1'b1, 16'(16'h0200 + tagn*4 + i), 16'(16'hC000 + tagn*16 + i)});
        end
        auto_drop = mask;
        cyc_nx    = mask;
        first     = mask[rr_ptr] ? rr_ptr : 1 - rr_ptr;
        second    = 1 - first;
        step();
        check_eq("arb_idle_gnt", 32'(gnt), 32'd0);
        step();
        check_eq("arb_first", 32'(gnt), 32'(1 << first));
        wait_drop(first);
        rr_ptr = (first + 1) % NM;
        step();
        if (mask[second]) begin
            check_eq("arb_handover", 32'(gnt), 32'(1 << second));
            wait_drop(second);
            rr_ptr = (second + 1) % NM;
            step();
        end
        check_eq("arb_release", 32'(gnt), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] pats [8];
        int k;
        pats = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01};
        rst_n    = 1'b0;
        m_adr    = '0;
        m_dat_i  = '0;
        s_dat_i  = '0;
        s_stall  = 1'b0;
        cyc_n    = 0;
        lat      = 1;
        saw_full = 1'b0;
        for (int i = 0; i < NM; i++) ack_cnt[i] = 0;
        clear_models();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_s_cyc", 32'(s_cyc), 32'd0);
        check_eq("rst_s_stb", 32'(s_stb), 32'd0);
        check_eq("rst_m_stall", 32'(m_stall), 32'd3);
        check_eq("rst_m_ack", 32'(m_ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single master, three zero-wait reads.
        lat = 1;
        for (int i = 0; i < 3; i++) ops[0].push_back({1'b0, 16'(16'h0100 + i*4), 16'h0000});
        auto_drop[0] = 1'b1;
        cyc_nx[0]    = 1'b1;
        step();
        check_eq("t1_idle_gnt", 32'(gnt), 32'd0);
        check_eq("t1_idle_stall", 32'(m_stall[0]), 32'd1);
        step();
        check_eq("t1_gnt", 32'(gnt), 32'd1);
        wait_drop(0);
        check_eq("t1_fall_gnt", 32'(gnt), 32'd1);
        step();
        check_eq("t1_release", 32'(gnt), 32'd0);
        check_eq("t1_acks", 32'(ack_cnt[0]), 32'd3);

        // Contention rounds: round-robin order and idle-free handover.
        do_reset();
        for (int r = 0; r < 8; r++) contend(pats[r], r);

        // Outstanding limit with a slow slave.
        do_reset();
        lat = 3;
        k = ack_cnt[0];
        saw_full = 1'b0;
        for (int i = 0; i < 4; i++) ops[0].push_back({1'b0, 16'(16'h0300 + i*4), 16'h0000});
        auto_drop[0] = 1'b1;
        cyc_nx[0]    = 1'b1;
        step();
        step();
        wait_drop(0);
        check_eq("t3_acks", 32'(ack_cnt[0] - k), 32'd4);
        check_eq("t3_full_seen", 32'(saw_full), 32'd1);
        step();
        check_eq("t3_release", 32'(gnt), 32'd0);

        // Abort with two outstanding while master 1 waits.
        do_reset();
        lat = 3;
        ops[0].push_back({1'b0, 16'h0400, 16'h0000});
        ops[0].push_back({1'b0, 16'h0404, 16'h0000});
        ops[1].push_back({1'b0, 16'h0500, 16'h0000});
        auto_drop[1] = 1'b1;
        cyc_nx       = 2'b11;
        step();
        k = 0;
        while (exp_q[0].size() < 2 && k < 10) begin
            step();
            k++;
        end
        check_eq("t4_two_out", 32'(exp_q[0].size()), 32'd2);
        cyc_nx[0] = 1'b0;
        exp_q[0].delete();
        step();
        k = 0;
        while (spq.size() > 0 && k < 10) begin
            step();
            k++;
            check_eq("t4_drain_stb", 32'(s_stb), 32'd0);
            check_eq("t4_drain_cyc", 32'(s_cyc), 32'd1);
            check_eq("t4_drain_ack", 32'(m_ack), 32'd0);
            check_eq("t4_drain_stall", 32'(m_stall), 32'd3);
        end
        step();
        check_eq("t4_handover", 32'(gnt), 32'd2);
        wait_drop(1);
        step();
        check_eq("t4_release", 32'(gnt), 32'd0);

        // Stray acks with nothing outstanding are dropped and leave the count at zero.
        do_reset();
        lat     = 1;
        inj_ack = 1'b1;
        step();
        check_eq("sp_idle_ack", 32'(m_ack), 32'd0);
        cyc_nx[0] = 1'b1;
        inj_ack   = 1'b0;
        step();
        inj_ack = 1'b1;
        step();
        check_eq("sp_owned_gnt", 32'(gnt), 32'd1);
        check_eq("sp_owned_ack", 32'(m_ack), 32'd0);
        inj_ack   = 1'b0;
        cyc_nx[0] = 1'b0;
        step();
        step();
        check_eq("sp_release", 32'(gnt), 32'd0);

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        lat = 3;
        ops[0].push_back({1'b0, 16'h0600, 16'h0000});
        ops[0].push_back({1'b0, 16'h0604, 16'h0000});
        cyc_nx[0] = 1'b1;
        step();
        step();
        check_eq("t6_one_out", 32'(exp_q[0].size()), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_s_cyc", 32'(s_cyc), 32'd0);
        check_eq("t6_rst_gnt", 32'(gnt), 32'd0);
        check_eq("t6_rst_m_stall", 32'(m_stall), 32'd3);
        check_eq("t6_rst_m_ack", 32'(m_ack), 32'd0);
        clear_models();
        @(negedge clk);
        rst_n = 1'b1;
        lat   = 1;
        contend(2'b11, 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
